ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter that shares the single-ported, byte-laned, synchronous-read word RAM between the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write with byte strobes).
- Sits between the CPU core's two memory interfaces and the RAM's addr/cs_n/we_n/data_i/data_o pins.
- Grants at most one access per cycle: fixed priority to the data port, with a bounded-wait override so instruction fetch cannot starve.
- Routes the registered RAM read data back to whichever port issued the read.

Parameters:
- ADDR_WIDTH, 15: byte-address width; word address bits are [ADDR_WIDTH-1:2], matching the RAM.
- MAX_WAIT, 4: consecutive cycles port 0 may be denied while requesting before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  port 0 read request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH-2  port 0 word address [ADDR_WIDTH-1:2]
- i_gnt  out  1  port 0 granted this cycle (combinational)
- i_rvalid  out  1  port 0 read data valid (cycle after grant)
- i_rdata  out  32  port 0 read data
- d_req  in  1  port 1 request; held with d_addr/d_wstrb/d_wdata until d_gnt
- d_addr  in  ADDR_WIDTH-2  port 1 word address
- d_wstrb  in  4  byte write strobes; 0000 = read, nonzero = write of strobed lanes
- d_wdata  in  32  port 1 write data
- d_gnt  out  1  port 1 granted this cycle (combinational)
- d_rvalid  out  1  port 1 read data valid (cycle after a read grant; never for writes)
- d_rdata  out  32  port 1 read data
- ram_addr  out  ADDR_WIDTH-2  to RAM addr
- ram_cs_n  out  4  to RAM cs_n, active low per byte lane
- ram_we_n  out  4  to RAM we_n, active low per byte lane
- ram_wdata  out  32  to RAM data_i
- ram_rdata  in  32  from RAM data_o

Behaviour:
- Grant logic (combinational, same cycle as request):
  - Only i_req: grant port 0.
  - Only d_req: grant port 1.
  - Both, and wait_cnt < MAX_WAIT: grant port 1.
  - Both, and wait_cnt >= MAX_WAIT: grant port 0.
  - i_gnt and d_gnt are never both high.
  - Both gnt outputs are 0 while reset=1.
- wait_cnt (4-bit register):
  - Reset to 0.
  - Increments when i_req=1 and i_gnt=0, saturating at 15.
  - Clears to 0 on i_gnt, or whenever i_req=0.
- RAM drive (combinational from the grant):
  - No grant (idle or reset): ram_cs_n=1111, ram_we_n=1111, ram_addr=0, ram_wdata=0.
  - Port 0 grant: ram_addr=i_addr, ram_cs_n=0000, ram_we_n=1111.
  - Port 1 read: ram_addr=d_addr, ram_cs_n=0000, ram_we_n=1111.
  - Port 1 write: ram_addr=d_addr, ram_cs_n=~d_wstrb, ram_we_n=~d_wstrb, ram_wdata=d_wdata. Unstrobed lanes are neither selected nor written.
- Read return (1-cycle latency, matching the RAM's registered data_o):
  - Register rd_owner (2 bits: valid flag plus port id) at each edge. Set it on any read grant; clear it on idle cycles, on writes, and on reset.
  - In the cycle after the grant: the owner's rvalid=1 and its rdata=ram_rdata. Full 32-bit word; byte/half extraction belongs to the core.
  - The non-owner's rdata=0 and rvalid=0.
- Pipelining:
  - A new grant may issue every cycle, including the cycle in which the previous read returns.
  - Back-to-back reads from the same or alternating ports need no bubble.
  - A write immediately after a read to the same address returns the old data for the read.
- Handshake rules:
  - A requester keeps req and its fields stable until gnt.
  - Req dropping without a grant is legal; the request is lost and wait_cnt clears.
  - The request fields are sampled only in the grant cycle.
- Reset behaviour:
  - rd_owner and wait_cnt clear, so no rvalid appears in the cycle after reset even if a read was granted in the cycle before.
  - All RAM strobes are held inactive while reset=1.

Test Plan:
- Reset: hold reset 3 cycles with i_req=d_req=1 -> gnt both 0, ram_cs_n=1111, ram_we_n=1111; first cycle after reset deasserts shows no rvalid.
- Single write then read: d_req, d_addr=0x010, d_wstrb=0011, d_wdata=0xAABBCCDD -> ram_cs_n=1100, ram_we_n=1100. Next, d_wstrb=0000 read of the same address -> d_rvalid one cycle later; d_rdata low half=0xCCDD, upper half=prior contents.
- Contention/anti-starvation with MAX_WAIT=4: hold i_req and d_req continuously -> d_gnt for 4 cycles, i_gnt on cycle 5, then the pattern repeats (4:1). i_rvalid appears exactly one cycle after each i_gnt.
- Back-to-back alternating reads: i_addr=0x004 then d_addr=0x008 on consecutive cycles -> i_rvalid then d_rvalid on consecutive cycles, each carrying the correct preloaded word, with no bubble.
- Reset mid-read: grant a port 0 read, then assert reset on the next edge -> i_rvalid stays 0; after release, wait_cnt restarts at 0 (verify with the contention pattern).
- Request withdrawn: i_req high for 2 cycles of contention, then low for 1 cycle, then high again -> wait_cnt restarts. i_gnt is not forced until 4 further denied cycles have elapsed.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one byte-laned synchronous-read RAM between the
// instruction-fetch port (0, read-only) and the load/store port (1).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-3:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-3:0] d_addr,
  input  logic [3:0]            d_wstrb,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [3:0]            ram_cs_n,
  output logic [3:0]            ram_we_n,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  logic [3:0] wait_cnt;
  logic       force_i;
  logic       d_write;
  logic       rd_vld_p1;
  logic       rd_port_p1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Stage p0: same-cycle grant and RAM pin drive
  always_comb begin
    force_i   = (wait_cnt >= 4'(MAX_WAIT));
    d_write   = (d_wstrb != 4'b0000);
    i_gnt     = !reset && i_req && (!d_req || force_i);
    d_gnt     = !reset && d_req && !(i_req && force_i);
    ram_addr  = '0;
    ram_cs_n  = 4'hF;
    ram_we_n  = 4'hF;
    ram_wdata = '0;
    if (i_gnt) begin
      ram_addr = i_addr;
      ram_cs_n = 4'h0;
    end else if (d_gnt) begin
      ram_addr = d_addr;
      if (d_write) begin
        // Unstrobed lanes stay deselected so their contents are untouched.
        ram_cs_n  = ~d_wstrb;
        ram_we_n  = ~d_wstrb;
        ram_wdata = d_wdata;
      end else begin
        ram_cs_n = 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (!i_req || i_gnt) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= sat_inc4(wait_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1  <= 1'b0;
      rd_port_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= i_gnt || (d_gnt && !d_write);
      rd_port_p1 <= d_gnt;
    end
  end

  // Stage p1: RAM data_o is registered, so it lines up with rd_vld_p1
  always_comb begin
    i_rvalid = !reset && rd_vld_p1 && !rd_port_p1;
    d_rvalid = !reset && rd_vld_p1 && rd_port_p1;
    i_rdata  = i_rvalid ? ram_rdata : 32'h0;
    d_rdata  = d_rvalid ? ram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a behavioural RAM on the pins and a
// shadow-memory reference model of grants, strobes and read returns.
module tb_ram_arbiter;
  localparam int AW = 13;
  localparam int MW = 4;

  logic          clk, rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [31:0]   i_rdata, d_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_cs_n, ram_we_n;
  logic [31:0]   ram_wdata, ram_q;

  logic [31:0] ram_mem [0:8191];
  logic [31:0] ref_mem [0:8191];

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_WIDTH(15), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
    .ram_wdata(ram_wdata), .ram_rdata(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte-laned RAM with registered read data
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (!ram_cs_n[b] && !ram_we_n[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    if (ram_cs_n != 4'hF) ram_q <= ram_mem[ram_addr];
  end

  // Reference model state
  int          m_wait;
  logic        pend_i, pend_d;
  logic [31:0] pend_data;
  logic        e_igant, e_dgnt, e_ivld, e_dvld, e_wchk;
  logic [3:0]  e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [31:0] e_wdata, e_irdata, e_drdata;

  task automatic eval_model();
    e_igant  = !rst && i_req && (!d_req || m_wait >= MW);
    e_dgnt   = !rst && d_req && !e_igant;
    e_cs     = 4'hF; e_we = 4'hF; e_addr = '0; e_wdata = '0; e_wchk = 1'b1;
    if (e_igant) begin
      e_cs = 4'h0; e_addr = i_addr; e_wchk = 1'b0;
    end else if (e_dgnt) begin
      e_addr = d_addr;
      if (d_wstrb == 4'h0) begin
        e_cs = 4'h0; e_wchk = 1'b0;
      end else begin
        e_cs = ~d_wstrb; e_we = ~d_wstrb; e_wdata = d_wdata;
      end
    end
    e_ivld   = pend_i && !rst;
    e_dvld   = pend_d && !rst;
    e_irdata = e_ivld ? pend_data : 32'h0;
    e_drdata = e_dvld ? pend_data : 32'h0;
  endtask

  task automatic advance();
    if (rst || !i_req || e_igant) m_wait = 0;
    else if (m_wait < 15) m_wait = m_wait + 1;
    pend_i = e_igant;
    pend_d = e_dgnt && (d_wstrb == 4'h0);
    pend_data = e_igant ? ref_mem[i_addr] : ref_mem[d_addr];
    if (e_dgnt && d_wstrb != 4'h0)
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) ref_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    eval_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1;
    i_addr = 13'h3; d_addr = 13'h5; d_wstrb = 4'hF; d_wdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_tests++; if ({i_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt}); end
      n_tests++; if ({ram_cs_n, ram_we_n} !== 8'hFF) begin n_fail++; $display("FAIL reset_strobes: got %h want ff", {ram_cs_n, ram_we_n}); end
      advance();
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    settle();
    n_tests++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
    advance();
  endtask

  task automatic test_write_read();
    logic [31:0] prior;
    prior = ref_mem[16];
    d_req = 1'b1; d_addr = 13'h010; d_wstrb = 4'b0011; d_wdata = 32'hAABBCCDD;
    settle();
    n_tests++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got %b%b want 01", i_gnt, d_gnt); end
    n_tests++; if (ram_cs_n !== 4'b1100 || ram_we_n !== 4'b1100) begin n_fail++; $display("FAIL wr_strobes: got cs %b we %b want 1100 1100", ram_cs_n, ram_we_n); end
    n_tests++; if (ram_addr !== 13'h010 || ram_wdata !== 32'hAABBCCDD) begin n_fail++; $display("FAIL wr_bus: got %h %h want 010 aabbccdd", ram_addr, ram_wdata); end
    advance();
    d_wstrb = 4'b0000;
    settle();
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", d_rvalid); end
    n_tests++; if (ram_cs_n !== 4'h0 || ram_we_n !== 4'hF) begin n_fail++; $display("FAIL rd_strobes: got cs %b we %b want 0000 1111", ram_cs_n, ram_we_n); end
    advance();
    d_req = 1'b0;
    settle();
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== {prior[31:16], 16'hCCDD}) begin
      n_fail++; $display("FAIL rd_data: got %b %h want 1 %h", d_rvalid, d_rdata, {prior[31:16], 16'hCCDD}); end
    n_tests++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_nonowner: got %b %h want 0 0", i_rvalid, i_rdata); end
    advance();
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_addr = 13'h004; d_req = 1'b0;
    settle(); advance();
    i_req = 1'b0; d_req = 1'b1; d_addr = 13'h008; d_wstrb = 4'h0;
    settle();
    n_tests++; if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[4]) begin n_fail++; $display("FAIL b2b_i: got %b %h want 1 %h", i_rvalid, i_rdata, ref_mem[4]); end
    n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_dgnt: got %b want 1", d_gnt); end
    advance();
    d_req = 1'b0;
    settle();
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[8] || i_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_d: got %b %h %b want 1 %h 0", d_rvalid, d_rdata, i_rvalid, ref_mem[8]); end
    advance();
  endtask

  // Both ports request continuously; port 0 must win exactly every fifth cycle.
  task automatic contend(input int n, input string tag);
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      settle();
      n_tests++; if (i_gnt !== (k % 5 == 4) || d_gnt !== (k % 5 != 4)) begin
        n_fail++; $display("FAIL %s_gnt[%0d]: got %b%b want %b%b", tag, k, i_gnt, d_gnt, k % 5 == 4, k % 5 != 4); end
      n_tests++; if (i_rvalid !== e_ivld || i_rdata !== e_irdata || d_rvalid !== e_dvld || d_rdata !== e_drdata) begin
        n_fail++; $display("FAIL %s_ret[%0d]: got %b %h %b %h want %b %h %b %h", tag, k,
                           i_rvalid, i_rdata, d_rvalid, d_rdata, e_ivld, e_irdata, e_dvld, e_drdata); end
      advance();
      if (e_igant) i_addr = AW'($urandom_range(0, 15));
      if (e_dgnt) begin
        d_addr = AW'($urandom_range(0, 15)); d_wstrb = 4'($urandom); d_wdata = $urandom;
      end
    end
  endtask

  task automatic test_contention();
    i_addr = 13'h2; d_addr = 13'h3; d_wstrb = 4'h0;
    contend(15, "cont");
    i_req = 1'b0; d_req = 1'b0;
    settle(); advance();
  endtask

  task automatic test_reset_mid_read();
    i_req = 1'b1; i_addr = 13'h7; d_req = 1'b0;
    settle();
    n_tests++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", i_gnt); end
    advance();
    i_req = 1'b0; rst = 1'b1;
    settle();
    n_tests++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_in: got %b want 0", i_rvalid); end
    advance();
    rst = 1'b0;
    settle();
    n_tests++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_after: got %b want 0", i_rvalid); end
    advance();
    d_wstrb = 4'h0;
    contend(5, "rmid");
    i_req = 1'b0; d_req = 1'b0;
    settle(); advance();
  endtask

  task automatic test_withdraw();
    i_req = 1'b1; d_req = 1'b1; d_wstrb = 4'h0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) i_req = 1'b0;
      settle();
      n_tests++; if (i_gnt !== 1'b0 || d_gnt !== 1'b1) begin n_fail++; $display("FAIL wd_pre[%0d]: got %b%b want 01", k, i_gnt, d_gnt); end
      advance();
    end
    contend(5, "wd");
    i_req = 1'b0; d_req = 1'b0;
    settle(); advance();
  endtask

  task automatic test_random();
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      settle();
      n_tests++; if (i_gnt !== e_igant || d_gnt !== e_dgnt) begin
        n_fail++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", k, i_gnt, d_gnt, e_igant, e_dgnt); end
      n_tests++; if (ram_cs_n !== e_cs || ram_we_n !== e_we || ram_addr !== e_addr || (e_wchk && ram_wdata !== e_wdata)) begin
        n_fail++; $display("FAIL rnd_ram[%0d]: got %b %b %h %h want %b %b %h %h", k,
                           ram_cs_n, ram_we_n, ram_addr, ram_wdata, e_cs, e_we, e_addr, e_wdata); end
      n_tests++; if (i_rvalid !== e_ivld || i_rdata !== e_irdata || d_rvalid !== e_dvld || d_rdata !== e_drdata) begin
        n_fail++; $display("FAIL rnd_ret[%0d]: got %b %h %b %h want %b %h %b %h", k,
                           i_rvalid, i_rdata, d_rvalid, d_rdata, e_ivld, e_irdata, e_dvld, e_drdata); end
      advance();
      if (!i_req || e_igant || $urandom_range(0, 9) == 0) begin
        i_req = 1'($urandom); i_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req || e_dgnt || $urandom_range(0, 9) == 0) begin
        d_req = 1'($urandom); d_addr = AW'($urandom_range(0, 15));
        d_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom); d_wdata = $urandom;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) begin
      ram_mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
      ref_mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    end
    m_wait = 0; pend_i = 1'b0; pend_d = 1'b0; pend_data = '0; ram_q = '0;
    #1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_contention();
    test_reset_mid_read();
    test_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
